pa_fdsu_norm_sched: RTL and testbench



---
 rtl/pa_fdsu_norm_sched_pkg.sv | 24 ++
 rtl/pa_fdsu_norm_sched_if.sv | 40 ++++
 rtl/pa_fdsu_norm_sched_ff.sv | 26 ++
 rtl/pa_fdsu_norm_sched.sv | 76 +++++++
 tb/tb_pa_fdsu_norm_sched.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pa_fdsu_norm_sched_pkg.sv
// Shared types and constants for the FDSU operand normalizer scheduler.
// The result register layout and the IDLE/FULL state encoding live here.
package pa_fdsu_pkg;

  localparam int FRAC_W    = 52;
  localparam int EXPADJ_W  = 13;
  localparam int LZ_W      = 6;
  localparam int RES_TAG_W = 4;
  localparam logic [EXPADJ_W-1:0] EXPADJ_ZERO = 13'h1fcc;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  typedef struct packed {
    logic                 src;
    logic [RES_TAG_W-1:0] tag;
    logic [FRAC_W-1:0]    frac;
    logic [EXPADJ_W-1:0]  expadj;
    logic                 zero;
  } res_t;

endpackage

// File: rtl/pa_fdsu_norm_sched_if.sv
// Requester and result handshake bundle between operand prep, the scheduler
// and the divide/sqrt front end.
interface pa_fdsu_norm_sched_if #(
  parameter int TAG_W = 4
);
  import pa_fdsu_pkg::*;

  logic                req0_vld;
  logic                req0_rdy;
  logic [FRAC_W-1:0]   req0_frac;
  logic [TAG_W-1:0]    req0_tag;
  logic                req1_vld;
  logic                req1_rdy;
  logic [FRAC_W-1:0]   req1_frac;
  logic [TAG_W-1:0]    req1_tag;
  logic                res_vld;
  logic                res_rdy;
  logic                res_src;
  logic [TAG_W-1:0]    res_tag;
  logic [FRAC_W-1:0]   res_frac;
  logic [EXPADJ_W-1:0] res_expadj;
  logic                res_zero;

  modport master (
    output req0_vld, req0_frac, req0_tag,
    output req1_vld, req1_frac, req1_tag,
    output res_rdy,
    input  req0_rdy, req1_rdy,
    input  res_vld, res_src, res_tag, res_frac, res_expadj, res_zero
  );

  modport slave (
    input  req0_vld, req0_frac, req0_tag,
    input  req1_vld, req1_frac, req1_tag,
    input  res_rdy,
    output req0_rdy, req1_rdy,
    output res_vld, res_src, res_tag, res_frac, res_expadj, res_zero
  );

endinterface

// File: rtl/pa_fdsu_norm_sched_ff.sv
// Combinational leading-zero normalizer: shifts the fraction left until its
// MSB is set and reports minus the shift as the exponent adjustment.
module pa_fdsu_ff
  import pa_fdsu_pkg::*;
(
  input  logic [FRAC_W-1:0]   frac,
  output logic [FRAC_W-1:0]   frac_norm,
  output logic [EXPADJ_W-1:0] expadj,
  output logic                zero
);

  logic [LZ_W-1:0] lz;

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    lz = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (frac[i]) lz = LZ_W'(FRAC_W - 1 - i);
    end
  end

  assign zero      = (frac == '0);
  assign frac_norm = frac << lz;
  assign expadj    = zero ? EXPADJ_ZERO : (EXPADJ_W'(0) - EXPADJ_W'(lz));

endmodule

// File: rtl/pa_fdsu_norm_sched.sv
// Round-robin scheduler sharing one normalizer between the dividend/radicand
// and divisor requesters, with a single registered valid/ready result stage.
module pa_fdsu_norm_sched
  import pa_fdsu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic forever_cpuclk,
  input  logic cpurst,
  input  logic flush,
  pa_fdsu_norm_sched_if.slave bus
);

  state_t              state_p1;
  logic                prefer1_p1;
  res_t                res_p1;

  logic                grant0;
  logic                grant1;
  logic                out_free;
  logic                accept;
  logic [FRAC_W-1:0]   frac_sel;
  logic [TAG_W-1:0]    tag_sel;
  logic [FRAC_W-1:0]   norm_frac;
  logic [EXPADJ_W-1:0] norm_expadj;
  logic                norm_zero;

  // Grant depends on valids and the pointer only, never on res_rdy.
  assign grant1   = bus.req1_vld & (~bus.req0_vld | prefer1_p1);
  assign grant0   = bus.req0_vld & ~grant1;
  assign out_free = (state_p1 == IDLE) | bus.res_rdy;

  assign bus.req0_rdy = grant0 & out_free & ~flush & ~cpurst;
  assign bus.req1_rdy = grant1 & out_free & ~flush & ~cpurst;
  assign accept       = bus.req0_rdy | bus.req1_rdy;

  assign frac_sel = grant1 ? bus.req1_frac : bus.req0_frac;
  assign tag_sel  = grant1 ? bus.req1_tag  : bus.req0_tag;

  pa_fdsu_ff u_ff (
    .frac      (frac_sel),
    .frac_norm (norm_frac),
    .expadj    (norm_expadj),
    .zero      (norm_zero)
  );

  // p0 -> p1: capture the normalized operand into the result stage
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_p1   <= IDLE;
      prefer1_p1 <= 1'b0;
      res_p1     <= '0;
    end else if (flush) begin
      state_p1   <= IDLE;
      prefer1_p1 <= 1'b0;
    end else if (accept) begin
      state_p1      <= FULL;
      prefer1_p1    <= grant0;
      res_p1.src    <= grant1;
      res_p1.tag    <= RES_TAG_W'(tag_sel);
      res_p1.frac   <= norm_frac;
      res_p1.expadj <= norm_expadj;
      res_p1.zero   <= norm_zero;
    end else if (bus.res_rdy) begin
      state_p1 <= IDLE;
    end
  end

  assign bus.res_vld    = (state_p1 == FULL);
  assign bus.res_src    = res_p1.src;
  assign bus.res_tag    = TAG_W'(res_p1.tag);
  assign bus.res_frac   = res_p1.frac;
  assign bus.res_expadj = res_p1.expadj;
  assign bus.res_zero   = res_p1.zero;

endmodule

// File: tb/tb_pa_fdsu_norm_sched.sv
// Directed and randomized bench for pa_fdsu_norm_sched against a cycle-level
// behavioural model of arbitration, result occupancy and normalization.
module tb_pa_fdsu_norm_sched;
  import pa_fdsu_pkg::*;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic cpurst;
  logic flush;
  always #5 clk = ~clk;

  pa_fdsu_norm_sched_if #(.TAG_W(TAG_W)) bus ();

  pa_fdsu_norm_sched #(.TAG_W(TAG_W)) dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .flush          (flush),
    .bus            (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_vld  = 1'b0;
  bit          m_src  = 1'b0;
  logic [3:0]  m_tag  = '0;
  logic [51:0] m_frac = '0;
  logic [12:0] m_exp  = '0;
  bit          m_zero = 1'b0;
  int          m_last = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_norm(input logic [51:0] f, output logic [51:0] fn,
                          output logic [12:0] e, output bit z);
    int lz;
    lz = 0;
    if (f == 52'd0) begin
      fn = '0; e = 13'h1fcc; z = 1'b1;
    end else begin
      fn = f;
      while (fn[51] == 1'b0) begin
        fn = fn << 1;
        lz++;
      end
      e = 13'(-lz);
      z = 1'b0;
    end
  endtask

  task automatic drive(input bit v0, input logic [51:0] f0, input logic [3:0] t0,
                       input bit v1, input logic [51:0] f1, input logic [3:0] t1,
                       input bit rr, input bit fl, input bit rs);
    bus.req0_vld = v0; bus.req0_frac = f0; bus.req0_tag = t0;
    bus.req1_vld = v1; bus.req1_frac = f1; bus.req1_tag = t1;
    bus.res_rdy  = rr; flush = fl; cpurst = rs;
  endtask

  // One clock: inputs are already applied at posedge+1.
  task automatic tick();
    int g;
    bit can;
    bit was_rst;
    logic [51:0] f;
    logic [3:0] t;
    #3;
    if (bus.req0_vld && bus.req1_vld) g = (m_last == 0) ? 1 : 0;
    else if (bus.req0_vld) g = 0;
    else if (bus.req1_vld) g = 1;
    else g = -1;
    can = (!m_vld || bus.res_rdy) && !flush && !cpurst;
    chk("req0_rdy", 64'(bus.req0_rdy), 64'(can && g == 0));
    chk("req1_rdy", 64'(bus.req1_rdy), 64'(can && g == 1));
    f = (g == 1) ? bus.req1_frac : bus.req0_frac;
    t = (g == 1) ? bus.req1_tag  : bus.req0_tag;
    was_rst = cpurst;
    @(posedge clk);
    #1;
    if (was_rst) begin
      m_vld = 0; m_src = 0; m_tag = '0; m_frac = '0; m_exp = '0; m_zero = 0; m_last = -1;
    end else if (flush) begin
      m_vld = 0; m_last = -1;
    end else if (can && g >= 0) begin
      m_vld = 1; m_src = (g == 1); m_tag = t; m_last = g;
      ref_norm(f, m_frac, m_exp, m_zero);
    end else if (bus.res_rdy) begin
      m_vld = 0;
    end
    chk("res_vld", 64'(bus.res_vld), 64'(m_vld));
    if (m_vld || was_rst) begin
      chk("res_src",    64'(bus.res_src),    64'(m_src));
      chk("res_tag",    64'(bus.res_tag),    64'(m_tag));
      chk("res_frac",   64'(bus.res_frac),   64'(m_frac));
      chk("res_expadj", 64'(bus.res_expadj), 64'(m_exp));
      chk("res_zero",   64'(bus.res_zero),   64'(m_zero));
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [51:0] fa, fb;
    bit src_seq [4];
    drive(0, '0, '0, 0, '0, '0, 1, 0, 1);
    #1;
    tick();
    chk("rst_vld", 64'(bus.res_vld), 64'd0);

    // 1: req0 only, already normalized
    drive(1, 52'h8000000000000, 4'd3, 0, '0, '0, 1, 0, 0);
    tick();
    chk("t1_vld", 64'(bus.res_vld), 64'd1);
    chk("t1_src", 64'(bus.res_src), 64'd0);
    chk("t1_tag", 64'(bus.res_tag), 64'd3);
    chk("t1_frac", 64'(bus.res_frac), 64'h8000000000000);
    chk("t1_expadj", 64'(bus.res_expadj), 64'h0000);
    chk("t1_zero", 64'(bus.res_zero), 64'd0);

    // 2: req1 only, lsb set then zero
    drive(0, '0, '0, 1, 52'h1, 4'd9, 1, 0, 0);
    tick();
    chk("t2_frac", 64'(bus.res_frac), 64'h8000000000000);
    chk("t2_expadj", 64'(bus.res_expadj), 64'h1fcd);
    chk("t2_src", 64'(bus.res_src), 64'd1);
    drive(0, '0, '0, 1, 52'h0, 4'd9, 1, 0, 0);
    tick();
    chk("t2z_frac", 64'(bus.res_frac), 64'd0);
    chk("t2z_expadj", 64'(bus.res_expadj), 64'h1fcc);
    chk("t2z_zero", 64'(bus.res_zero), 64'd1);

    // 3: both valid, alternating grants
    for (int i = 0; i < 4; i++) begin
      drive(1, 52'h0400000000000 >> i, 4'(i), 1, 52'h0000000ff0000, 4'(8 + i), 1, 0, 0);
      tick();
      chk("t3_vld", 64'(bus.res_vld), 64'd1);
      src_seq[i] = bus.res_src;
    end
    chk("t3_src0", 64'(src_seq[0]), 64'd0);
    chk("t3_src1", 64'(src_seq[1]), 64'd1);
    chk("t3_src2", 64'(src_seq[2]), 64'd0);
    chk("t3_src3", 64'(src_seq[3]), 64'd1);

    // 4: stall three cycles, then pop and accept together
    for (int i = 0; i < 3; i++) begin
      drive(1, 52'h00000000000f0, 4'd5, 1, 52'h0000100000000, 4'd6, 0, 0, 0);
      tick();
      chk("t4_hold_src", 64'(bus.res_src), 64'd1);
      chk("t4_hold_tag", 64'(bus.res_tag), 64'd11);
    end
    drive(1, 52'h00000000000f0, 4'd5, 1, 52'h0000100000000, 4'd6, 1, 0, 0);
    tick();
    chk("t4_vld", 64'(bus.res_vld), 64'd1);
    chk("t4_tag", 64'(bus.res_tag), 64'd5);

    // 5: flush while full and stalled
    drive(1, 52'h1234, 4'd1, 0, '0, '0, 0, 1, 0);
    tick();
    chk("t5_vld", 64'(bus.res_vld), 64'd0);
    drive(1, 52'h1234, 4'd1, 1, 52'h5678, 4'd2, 1, 0, 0);
    tick();
    chk("t5_src", 64'(bus.res_src), 64'd0);

    // 6: reset mid-result with both valid
    drive(1, 52'h1234, 4'd1, 1, 52'h5678, 4'd2, 0, 0, 1);
    tick();
    chk("t6_vld", 64'(bus.res_vld), 64'd0);
    chk("t6_frac", 64'(bus.res_frac), 64'd0);
    drive(1, 52'h1234, 4'd1, 1, 52'h5678, 4'd2, 1, 0, 0);
    tick();
    chk("t6_src", 64'(bus.res_src), 64'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r  = {$urandom(), $urandom()};
      fa = r[51:0] >> $urandom_range(0, 52);
      r  = {$urandom(), $urandom()};
      fb = r[51:0] >> $urandom_range(0, 52);
      drive(($urandom_range(0, 3) != 0), fa, 4'($urandom()),
            ($urandom_range(0, 3) != 0), fb, 4'($urandom()),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 39) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
